spart_baud_gen: RTL and testbench
=================================

// Module: spart_baud_gen
// PURPOSE
//  Programmable baud-rate generator for the SPART; sits upstream of the receiver and transmitter.
//  Holds a 16-bit divisor that the processor writes over the SPART I/O bus (DB_LOW/DB_HIGH).
//  Emits a one-cycle en_rx pulse every DIVISOR clocks, which feeds the receiver's `enable`.
//  Also emits a one-cycle en_tx pulse on every 16th en_rx pulse, which paces the transmitter.
// PARAMETERS
//  RESET_DIVISOR   16'd325  divisor loaded at reset (50 MHz / (16*9600))
//  TX_RATIO        16       en_rx pulses per en_tx pulse; must be a power of 2, 2..256
// PORTS
//  clk          input   1   system clock; one clock domain
//  rst          input   1   asynchronous, active-high reset
//  iocs         input   1   SPART chip select
//  iorw         input   1   1 = read, 0 = write
//  ioaddr       input   2   register select: 2'b10 = DB_LOW, 2'b11 = DB_HIGH
//  databus_in   input   8   write data from the processor bus
//  en_rx        output  1   16x-oversample tick, one cycle wide
//  en_tx        output  1   bit-rate tick, one cycle wide, coincides with an en_rx pulse
//  divisor      output  16  currently active divisor (debug/status)
// BEHAVIOUR
//  Write strobe: wr = iocs & ~iorw. Reads and accesses to addr 2'b00/2'b01 have no effect here.
//  DB_LOW write (wr & addr 2'b10):
//   - databus_in goes into low_buf only.
//   - The active divisor and the counters are unchanged.
//  DB_HIGH write (wr & addr 2'b11):
//   - Commits divisor <= {databus_in, low_buf} in the same edge.
//   - Reloads cnt <= new divisor - 1 and clears sub_cnt.
//   - en_rx and en_tx are 0 on the cycle after the commit.
//  Reset (async, any cycle, including mid-count):
//   - divisor = RESET_DIVISOR; low_buf = RESET_DIVISOR[7:0].
//   - cnt = RESET_DIVISOR - 1; sub_cnt = 0; en_rx = 0; en_tx = 0.
//  Rx tick counter (16-bit down-counter cnt), each non-commit cycle with divisor != 0:
//   - cnt == 0: cnt <= divisor - 1 and en_rx <= 1 (registered output).
//   - otherwise: cnt <= cnt - 1 and en_rx <= 0.
//   - Net effect: en_rx period is exactly `divisor` clocks.
//   - The first pulse is registered `divisor` cycles after a commit or reset release.
//   - divisor == 1: en_rx is held high continuously.
//   - divisor == 0: counter frozen at 0; en_rx = en_tx = 0 until a non-zero commit.
//  Tx subdivider (log2(TX_RATIO)-bit sub_cnt), advances only on cycles where en_rx is being set:
//   - sub_cnt == TX_RATIO-1: en_tx <= 1 and sub_cnt wraps to 0.
//   - otherwise: sub_cnt increments and en_tx <= 0.
//   - Result: en_tx rises in the same cycle as every TX_RATIO-th en_rx.
//  Simultaneous events:
//   - A commit on the same cycle cnt hits 0 wins: no pulse, reload applied.
//   - Writes to low_buf never disturb the tick stream.
//  Arithmetic is unsigned. divisor - 1 is evaluated only when divisor != 0, so no underflow.
// STRUCTURE
//  spart_pkg holds the shared constants:
//   - ADDR_TXRX = 2'b00, ADDR_STATUS = 2'b01, ADDR_DB_LOW = 2'b10, ADDR_DB_HIGH = 2'b11
//   - DIVISOR_W = 16
//   - the default baud divisor constant
//  The receiver and transmitter import the same package.
//  Sub-module spart_tick_div (load/enable down-counter with zero pulse) is instantiated once for en_rx.
//  The tx subdivider is inline.
// TESTING
//  1. Reset, no writes -> first en_rx 325 clks after reset release, then every 325; en_tx every 5200.
//  2. Write DB_LOW=0x04, DB_HIGH=0x00 -> en_rx every 4 clks; en_tx every 64 clks, aligned with en_rx.
//  3. Write DB_LOW=0x08 only -> divisor and tick period unchanged; a later DB_HIGH=0x00 -> period 8.
//  4. Commit 0x0000 -> no en_rx/en_tx for 1000 clks; commit 0x0001 -> en_rx constantly 1.
//  5. Read (iorw=1) or iocs=0 at addr 2'b11 with data 0xFF -> divisor unchanged.
//  6. Assert rst mid-period with divisor=4 -> outputs 0 immediately; divisor 325 after release.

Source files
------------

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared SPART constants: I/O register map and divisor width.
//  Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    localparam logic [1:0] ADDR_TXRX    = 2'b00;
    localparam logic [1:0] ADDR_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
    localparam logic [1:0] ADDR_DB_HIGH = 2'b11;

    localparam int DIVISOR_W = 16;

    // 50 MHz / (16 * 9600)
    localparam logic [DIVISOR_W-1:0] DEFAULT_DIVISOR = 16'd325;

endpackage
`default_nettype wire

// File: rtl/spart_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : spart_tick_div
//  Description : Loadable down-counter emitting a registered one-cycle tick
//                every i_period clocks; a zero period freezes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_tick_div #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_COUNT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_tick,
    output logic             o_hit
);

    logic [WIDTH-1:0] r_cnt;

    // o_hit marks the cycle on which o_tick is about to be set
    always_comb begin
        o_hit = !i_load && (i_period != '0) && (r_cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= RESET_COUNT;
            o_tick <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= (i_load_value != '0) ? (i_load_value - WIDTH'(1)) : '0;
            o_tick <= 1'b0;
        end else if (i_period == '0) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else if (o_hit) begin
            r_cnt  <= i_period - WIDTH'(1);
            o_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - WIDTH'(1);
            o_tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spart_baud_gen
//  Description : Programmable SPART baud generator: en_rx every divisor clocks,
//                en_tx on every TX_RATIO-th en_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [DIVISOR_W-1:0] RESET_DIVISOR = DEFAULT_DIVISOR,
    parameter int                   TX_RATIO      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iocs,
    input  logic                 iorw,
    input  logic [1:0]           ioaddr,
    input  logic [7:0]           databus_in,
    output logic                 en_rx,
    output logic                 en_tx,
    output logic [DIVISOR_W-1:0] divisor
);

    localparam int                   c_SUB_W     = $clog2(TX_RATIO);
    localparam logic [c_SUB_W-1:0]   c_SUB_LAST  = c_SUB_W'(TX_RATIO - 1);
    localparam logic [DIVISOR_W-1:0] c_RESET_CNT =
        (RESET_DIVISOR == '0) ? '0 : (RESET_DIVISOR - DIVISOR_W'(1));

    logic                 w_wr;
    logic                 w_wr_low;
    logic                 w_commit;
    logic                 w_rx_hit;
    logic [DIVISOR_W-1:0] w_new_div;

    logic [DIVISOR_W-1:0] r_divisor;
    logic [7:0]           r_low_buf;
    logic [c_SUB_W-1:0]   r_sub_cnt;
    logic                 r_en_tx;

    always_comb begin
        w_wr      = iocs && !iorw;
        w_wr_low  = w_wr && (ioaddr == ADDR_DB_LOW);
        w_commit  = w_wr && (ioaddr == ADDR_DB_HIGH);
        w_new_div = {databus_in, r_low_buf};
    end

    spart_tick_div #(
        .WIDTH       (DIVISOR_W),
        .RESET_COUNT (c_RESET_CNT)
    ) u_rx_div (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_commit),
        .i_load_value (w_new_div),
        .i_period     (r_divisor),
        .o_tick       (en_rx),
        .o_hit        (w_rx_hit)
    );

    // A commit takes priority over a coincident rx hit, so the tx phase restarts cleanly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor <= RESET_DIVISOR;
            r_low_buf <= RESET_DIVISOR[7:0];
            r_sub_cnt <= '0;
            r_en_tx   <= 1'b0;
        end else begin
            if (w_wr_low) begin
                r_low_buf <= databus_in;
            end
            if (w_commit) begin
                r_divisor <= w_new_div;
                r_sub_cnt <= '0;
                r_en_tx   <= 1'b0;
            end else if (w_rx_hit) begin
                if (r_sub_cnt == c_SUB_LAST) begin
                    r_sub_cnt <= '0;
                    r_en_tx   <= 1'b1;
                end else begin
                    r_sub_cnt <= r_sub_cnt + c_SUB_W'(1);
                    r_en_tx   <= 1'b0;
                end
            end else begin
                r_en_tx <= 1'b0;
            end
        end
    end

    assign en_tx   = r_en_tx;
    assign divisor = r_divisor;

endmodule
`default_nettype wire

// File: tb/tb_spart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_baud_gen
//  Description : Self-checking bench for spart_baud_gen against a phase model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_baud_gen;

    localparam int          c_TX_RATIO  = 16;
    localparam logic [15:0] c_RESET_DIV = 16'd325;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iocs = 1'b0;
    logic        iorw = 1'b1;
    logic [1:0]  ioaddr = 2'b00;
    logic [7:0]  databus_in = 8'h00;
    logic        en_rx;
    logic        en_tx;
    logic [15:0] divisor;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: active divisor, low buffer, and clocks elapsed since last commit/reset
    logic [15:0] m_div  = c_RESET_DIV;
    logic [7:0]  m_low  = c_RESET_DIV[7:0];
    longint      m_since = 0;

    typedef struct {
        logic        cs;
        logic        rw;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_div;
    } vec_t;

    spart_baud_gen #(
        .RESET_DIVISOR (c_RESET_DIV),
        .TX_RATIO      (c_TX_RATIO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus_in (databus_in),
        .en_rx      (en_rx),
        .en_tx      (en_tx),
        .divisor    (divisor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_rx();
        return !rst && (m_div != 0) && (m_since > 0) && ((m_since % longint'(m_div)) == 0);
    endfunction

    function automatic logic exp_tx();
        return exp_rx() && (((m_since / longint'(m_div)) % c_TX_RATIO) == 0);
    endfunction

    task automatic check_outputs();
        chk("en_rx", 32'(en_rx), 32'(exp_rx()));
        chk("en_tx", 32'(en_tx), 32'(exp_tx()));
        chk("divisor", 32'(divisor), 32'(m_div));
    endtask

    task automatic model_reset();
        m_div   = c_RESET_DIV;
        m_low   = c_RESET_DIV[7:0];
        m_since = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (iocs && !iorw && ioaddr == 2'b11) begin
            m_div   = {databus_in, m_low};
            m_since = 0;
        end else begin
            if (iocs && !iorw && ioaddr == 2'b10) m_low = databus_in;
            m_since++;
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic set_bus(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        iocs = cs; iorw = rw; ioaddr = a; databus_in = d;
    endtask

    task automatic idle();
        set_bus(1'b0, 1'b1, 2'b00, 8'h00);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        set_bus(1'b1, 1'b0, a, d);
        step();
        idle();
    endtask

    task automatic run(input int n, output int rx_n, output int tx_n);
        rx_n = 0; tx_n = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (en_rx) rx_n++;
            if (en_tx) tx_n++;
        end
    endtask

    task automatic first_latency(input string name);
        int first;
        first = -1;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (en_rx && first < 0) first = i;
        end
        chk(name, 32'(first), 32'd325);
    endtask

    initial begin
        vec_t vecs[9];
        int   rx_n, tx_n, rx2, tx2;
        logic seen;

        // Register-access vectors applied with divisor already at 0x0008
        vecs[0] = '{1'b1, 1'b1, 2'b11, 8'hFF, 16'h0008};
        vecs[1] = '{1'b0, 1'b0, 2'b11, 8'hFF, 16'h0008};
        vecs[2] = '{1'b1, 1'b0, 2'b00, 8'hFF, 16'h0008};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 8'hFF, 16'h0008};
        vecs[4] = '{1'b1, 1'b0, 2'b10, 8'h12, 16'h0008};
        vecs[5] = '{1'b1, 1'b1, 2'b10, 8'hAA, 16'h0008};
        vecs[6] = '{1'b0, 1'b0, 2'b10, 8'hBB, 16'h0008};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 8'h00, 16'h0012};
        vecs[8] = '{1'b1, 1'b0, 2'b10, 8'h05, 16'h0012};

        idle();
        rst = 1'b1;
        step();
        step();
        chk("reset_en_rx", 32'(en_rx), 32'd0);
        chk("reset_divisor", 32'(divisor), 32'd325);
        rst = 1'b0;

        // Default divisor: first tick 325 clocks after release, tx every 5200
        first_latency("first_rx_latency");
        run(10100, rx_n, tx_n);
        chk("default_rx_count", 32'(rx_n + 1), 32'd32);
        chk("default_tx_count", 32'(tx_n), 32'd2);

        bus_write(2'b10, 8'h04);
        bus_write(2'b11, 8'h00);
        chk("div4_value", 32'(divisor), 32'd4);
        run(128, rx_n, tx_n);
        chk("div4_rx_count", 32'(rx_n), 32'd32);
        chk("div4_tx_count", 32'(tx_n), 32'd2);

        bus_write(2'b10, 8'h08);
        run(40, rx_n, tx_n);
        chk("low_only_div", 32'(divisor), 32'd4);
        chk("low_only_rx_count", 32'(rx_n), 32'd10);
        bus_write(2'b11, 8'h00);
        chk("div8_value", 32'(divisor), 32'd8);
        run(80, rx_n, tx_n);
        chk("div8_rx_count", 32'(rx_n), 32'd10);

        for (int i = 0; i < 9; i++) begin
            set_bus(vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].data);
            step();
            idle();
            chk($sformatf("vec%0d_div", i), 32'(divisor), 32'(vecs[i].exp_div));
            run(3, rx_n, tx_n);
        end
        bus_write(2'b11, 8'h00);
        chk("vec_final_div", 32'(divisor), 32'd5);

        // Divisor 0 stalls everything; divisor 1 holds en_rx high
        bus_write(2'b10, 8'h00);
        bus_write(2'b11, 8'h00);
        run(1000, rx_n, tx_n);
        chk("div0_rx_count", 32'(rx_n), 32'd0);
        chk("div0_tx_count", 32'(tx_n), 32'd0);
        bus_write(2'b10, 8'h01);
        bus_write(2'b11, 8'h00);
        run(50, rx_n, tx_n);
        chk("div1_rx_count", 32'(rx_n), 32'd50);
        chk("div1_tx_count", 32'(tx_n), 32'd3);

        // Asynchronous reset landing while en_rx is high
        bus_write(2'b10, 8'h04);
        bus_write(2'b11, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (en_rx) seen = 1'b1;
        end
        chk("pre_reset_rx_seen", 32'(seen), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_en_rx", 32'(en_rx), 32'd0);
        chk("async_rst_en_tx", 32'(en_tx), 32'd0);
        chk("async_rst_divisor", 32'(divisor), 32'd325);
        step();
        step();
        rst = 1'b0;
        first_latency("post_reset_rx_latency");

        // Random bus traffic against the phase model
        rx2 = 0; tx2 = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)
                set_bus(1'b1, 1'b0, 2'b10, 8'($urandom_range(0, 12)));
            else if (r < 6)
                set_bus(1'b1, 1'b0, 2'b11, (r == 5 && $urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00);
            else if (r < 10)
                set_bus(1'($urandom), 1'b1, 2'($urandom), 8'($urandom));
            else if (r < 12)
                set_bus(1'b0, 1'b0, 2'($urandom), 8'($urandom));
            else
                idle();
            step();
            if (en_rx) rx2++;
            if (en_tx) tx2++;
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
